// File: rtl/fpu_pkg.sv
// Shared constants and FSM state type for the binary32 divider.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int ITERS = 26;
  localparam logic [31:0] QNAN = 32'h7fc00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/fdiv_lzc.sv
// Leading-zero counter for 24-bit significands; an all-zero input returns 24.
module fdiv_lzc (
  input  logic [23:0] a,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (a[i]) cnt = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fdiv.sv
// Iterative binary32 divider with a fixed 29-cycle accept-to-result latency.
// Define FDIV_SUBNORMAL_EN for subnormal inputs/results; otherwise they flush to signed zero.
module fdiv
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  // state   | meaning
  // S_IDLE  | waiting for operands, in_ready=1
  // S_PREP  | unpack, classify, exponent difference
  // S_DIV   | 26 restoring iterations, one quotient bit each
  // S_ROUND | phase 0 normalise/denormalise, phase 1 round and pack
  // S_DONE  | result held until out_ready

  state_t            state;
  logic [31:0]       a_r, b_r, spec_y_r;
  logic              sgn_r, spec_r, phase_r, stk_r;
  logic signed [9:0] exp_r;
  logic [MAN_W:0]    m2_r;
  logic [25:0]       rem_r, q_r, sig_r;
  logic [4:0]        cnt_r;

  logic [EXP_W-1:0]  e1f, e2f;
  logic [MAN_W-1:0]  f1, f2;
  logic              nan1, nan2, inf1, inf2, zero1, zero2, sgn, spec;
  logic [MAN_W:0]    m1, m2;
  logic signed [9:0] ex1, ex2, exq;
  logic [31:0]       spec_y;

  assign e1f = a_r[30:23];
  assign e2f = b_r[30:23];
  assign f1  = a_r[22:0];
  assign f2  = b_r[22:0];

`ifdef FDIV_SUBNORMAL_EN
  logic [4:0] lz1, lz2;
  fdiv_lzc u_lzc1 (.a({1'b0, f1}), .cnt(lz1));
  fdiv_lzc u_lzc2 (.a({1'b0, f2}), .cnt(lz2));
`endif

  always_comb begin
    nan1 = (e1f == 8'hff) && (f1 != '0);
    nan2 = (e2f == 8'hff) && (f2 != '0);
    inf1 = (e1f == 8'hff) && (f1 == '0);
    inf2 = (e2f == 8'hff) && (f2 == '0);
`ifdef FDIV_SUBNORMAL_EN
    zero1 = (e1f == '0) && (f1 == '0);
    zero2 = (e2f == '0) && (f2 == '0);
    m1  = (e1f == '0) ? ({1'b0, f1} << lz1) : {1'b1, f1};
    m2  = (e2f == '0) ? ({1'b0, f2} << lz2) : {1'b1, f2};
    ex1 = (e1f == '0) ? 10'sd1 - $signed({5'd0, lz1}) : $signed({2'b00, e1f});
    ex2 = (e2f == '0) ? 10'sd1 - $signed({5'd0, lz2}) : $signed({2'b00, e2f});
`else
    zero1 = (e1f == '0);
    zero2 = (e2f == '0);
    m1  = {1'b1, f1};
    m2  = {1'b1, f2};
    ex1 = $signed({2'b00, e1f});
    ex2 = $signed({2'b00, e2f});
`endif
    exq    = ex1 - ex2 + $signed(10'(BIAS));
    sgn    = a_r[31] ^ b_r[31];
    spec   = 1'b1;
    spec_y = QNAN;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) spec_y = QNAN;
    else if (inf1 || zero2)                                 spec_y = {sgn, 8'hff, 23'd0};
    else if (zero1 || inf2)                                 spec_y = {sgn, 31'd0};
    else                                                    spec   = 1'b0;
  end

  // The single shared subtractor; bit 25 set means the trial subtraction borrowed.
  logic [25:0] diff;
  assign diff = rem_r - {2'b00, m2_r};

  logic [25:0]       sn, sig_n;
  logic signed [9:0] en, exp_n;
  logic              stk_n;
`ifdef FDIV_SUBNORMAL_EN
  logic signed [9:0] sh;
  logic [4:0]        shc;
  logic [51:0]       wide;
`endif

  always_comb begin
    sn    = q_r[25] ? q_r : {q_r[24:0], 1'b0};
    en    = q_r[25] ? exp_r : exp_r - 10'sd1;
    sig_n = sn;
    exp_n = en;
    stk_n = (rem_r != '0);
`ifdef FDIV_SUBNORMAL_EN
    sh    = 10'sd1 - en;
    shc   = (sh > 10'sd27) ? 5'd27 : sh[4:0];
    wide  = {sn, 26'd0} >> shc;
    if (en < 10'sd1) begin
      sig_n = wide[51:26];
      stk_n = stk_n | (wide[25:0] != '0);
      exp_n = '0;
    end
`endif
  end

  logic [23:0]       mant, mf;
  logic              rup;
  logic [24:0]       rnd;
  logic signed [9:0] ef;
  logic [31:0]       res;

  always_comb begin
    mant = sig_r[25:2];
    rup  = sig_r[1] & (sig_r[0] | stk_r | mant[0]);
    rnd  = {1'b0, mant} + {24'd0, rup};
    mf   = rnd[24] ? rnd[24:1] : rnd[23:0];
    ef   = rnd[24] ? exp_r + 10'sd1 : exp_r;
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (ef == 10'sd0 && mf[23]) ef = 10'sd1;
    res = {sgn_r, ef[7:0], mf[22:0]};
    if (ef >= 10'sd255) res = {sgn_r, 8'hff, 23'd0};
`ifndef FDIV_SUBNORMAL_EN
    if (exp_r < 10'sd1) res = {sgn_r, 31'd0};
`endif
    if (spec_r) res = spec_y_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      phase_r   <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid && in_ready) begin
          a_r      <= x1;
          b_r      <= x2;
          in_ready <= 1'b0;
          state    <= S_PREP;
        end
        S_PREP: begin
          sgn_r    <= sgn;
          spec_r   <= spec;
          spec_y_r <= spec_y;
          exp_r    <= exq;
          m2_r     <= m2;
          rem_r    <= {2'b00, m1};
          q_r      <= '0;
          cnt_r    <= '0;
          state    <= S_DIV;
        end
        S_DIV: begin
          if (!diff[25]) begin
            rem_r <= {diff[24:0], 1'b0};
            q_r   <= {q_r[24:0], 1'b1};
          end else begin
            rem_r <= {rem_r[24:0], 1'b0};
            q_r   <= {q_r[24:0], 1'b0};
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'(ITERS - 1)) begin
            phase_r <= 1'b0;
            state   <= S_ROUND;
          end
        end
        S_ROUND: if (!phase_r) begin
          sig_r   <= sig_n;
          stk_r   <= stk_n;
          exp_r   <= exp_n;
          phase_r <= 1'b1;
        end else begin
          y         <= res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv.sv
// Randomised bench for fdiv against an exact integer-division model of binary32 division.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, y;

  int vectors = 0;
  int miscmp  = 0;

  fdiv dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Quotient = (ma/mb) * 2^(ea-eb), computed as one wide integer division.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic         s;
    logic [127:0] ma, mb, q, r, mant, below;
    int           ea, eb, e, p, lsb;
    bit           na, nb, ia, ib, za, zb, guard, sticky, up, flush;
    s  = a[31] ^ b[31];
    na = (a[30:23] == 8'hff) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hff) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hff) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hff) && (b[22:0] == 0);
`ifdef FDIV_SUBNORMAL_EN
    za = (a[30:0] == 0);
    zb = (b[30:0] == 0);
`else
    za = (a[30:23] == 0);
    zb = (b[30:23] == 0);
`endif
    if (na || nb || (za && zb) || (ia && ib)) return 32'h7fc00000;
    if (ia || zb) return {s, 8'hff, 23'd0};
    if (za || ib) return {s, 31'd0};
    ma = (a[30:23] == 0) ? {105'd0, a[22:0]} : {104'd0, 1'b1, a[22:0]};
    mb = (b[30:23] == 0) ? {105'd0, b[22:0]} : {104'd0, 1'b1, b[22:0]};
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    q  = (ma << 80) / mb;
    r  = (ma << 80) % mb;
    p  = 0;
    for (int i = 0; i < 128; i++) if (q[i]) p = i;
    e     = p - 80 + ea - eb + 127;
    flush = (e < 1);
    lsb   = p - 23;
`ifdef FDIV_SUBNORMAL_EN
    if (e < 1) begin
      lsb = lsb + (1 - e);
      e   = 0;
    end
`endif
    mant   = q >> lsb;
    guard  = ((q >> (lsb - 1)) & 128'd1) != 0;
    below  = q & ((128'd1 << (lsb - 1)) - 128'd1);
    sticky = (below != 0) || (r != 0);
    up     = guard && (sticky || mant[0]);
    mant   = mant + 128'(up);
    if (mant[24]) begin
      mant = mant >> 1;
      e++;
    end
    if (e == 0 && mant[23]) e = 1;
`ifndef FDIV_SUBNORMAL_EN
    if (flush) return {s, 31'd0};
`endif
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  // Model of the handshake: accept in idle, result exactly 29 edges later, held until out_ready.
  bit          started = 0, pending = 0, mon_rst;
  int          age;
  logic [31:0] exp_y;

  always @(posedge clk) begin
    mon_rst = rst;
    if (mon_rst) begin
      started = 1;
      pending = 0;
    end else if (pending) begin
      if (age >= 29 && out_ready) pending = 0;
      else age++;
    end else if (started && in_valid) begin
      pending = 1;
      age     = 0;
      exp_y   = ref_div(x1, x2);
    end
    #1;
    if (started) begin
      if (pending) begin
        chk("out_valid busy", 32'(out_valid), 32'(age >= 29));
        chk("in_ready busy", 32'(in_ready), 32'd0);
        if (age >= 29) chk("y", y, exp_y);
      end else begin
        chk("in_ready idle", 32'(in_ready), 32'd1);
        chk("out_valid idle", 32'(out_valid), 32'd0);
        if (mon_rst) chk("y after reset", y, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    @(negedge clk);
    x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      vectors++; miscmp++;
      $display("FAIL accept timeout: in_ready stuck at 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0; x1 = $urandom; x2 = $urandom;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      vectors++; miscmp++;
      $display("FAIL result timeout: out_valid stuck at 0, required 1");
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    int   k;
    logic s;
    k = $urandom_range(0, 11);
    s = 1'($urandom);
    case (k)
      0: return {s, 31'd0};
      1: return {s, 8'hff, 23'd0};
      2: return {1'b0, 8'hff, 23'($urandom) | 23'h1};
      3: return {s, 8'h00, 23'($urandom)};
      4: return {s, 8'($urandom_range(1, 24)), 23'($urandom)};
      5: return {s, 8'($urandom_range(230, 254)), 23'($urandom)};
      6: return {s, 8'($urandom_range(120, 134)), 23'($urandom) & 23'h7f0000};
      default: return {s, 8'($urandom_range(90, 164)), 23'($urandom)};
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;

    chk("model 6/2", ref_div(32'h40c00000, 32'h40000000), 32'h40400000);
    chk("model 1/3", ref_div(32'h3f800000, 32'h40400000), 32'h3eaaaaab);
    chk("model -1/0", ref_div(32'hbf800000, 32'h00000000), 32'hff800000);
    chk("model 0/0", ref_div(32'h00000000, 32'h00000000), 32'h7fc00000);
    chk("model nan", ref_div(32'h7fc00001, 32'h3f800000), 32'h7fc00000);
    chk("model inf/2", ref_div(32'hff800000, 32'h40000000), 32'hff800000);
    chk("model 3/inf", ref_div(32'h40400000, 32'h7f800000), 32'h00000000);
    chk("model overflow", ref_div(32'h7f000000, 32'h3e800000), 32'h7f800000);
`ifdef FDIV_SUBNORMAL_EN
    chk("model subnormal", ref_div(32'h00800000, 32'h40000000), 32'h00400000);
`else
    chk("model subnormal", ref_div(32'h00800000, 32'h40000000), 32'h00000000);
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(32'h40c00000, 32'h40000000, 0);
    run_op(32'h3f800000, 32'h40400000, 0);
    run_op(32'hbf800000, 32'h00000000, 1);
    run_op(32'h00000000, 32'h00000000, 0);
    run_op(32'h7fc00001, 32'h12345678, 0);
    run_op(32'h00800000, 32'h40000000, 0);
    run_op(32'h3f800000, 32'h40400000, 10);

    // Reset in the middle of the iterations, then a clean operation.
    @(negedge clk);
    x1 = 32'h40c00000; x2 = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h40c00000, 32'h40000000, 0);

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(rnd_op(), rnd_op(), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: `clk` (posedge) and `rst`.
REQ-002 Ports SHALL be:
- clk        in   1   clock
- rst        in   1   synchronous active-high reset
- in_valid   in   1   operands present
- in_ready   out  1   unit can accept operands
- x1         in   32  IEEE-754 binary32 dividend
- x2         in   32  IEEE-754 binary32 divisor
- out_valid  out  1   result present
- out_ready  in   1   consumer accepts result
- y          out  32  binary32 quotient x1/x2

Function
REQ-003 SHALL run the state machine IDLE -> PREP -> DIV -> ROUND -> DONE -> IDLE.
REQ-004 SHALL accept operands on the cycle where in_valid&&in_ready; in_ready SHALL be 1 only in IDLE.
REQ-005 SHALL register x1/x2 at accept, so that later changes on the inputs have no effect.
REQ-006 PREP SHALL unpack sign, exponent and mantissa with a hidden bit, classify NaN/inf/zero/subnormal, and compute sign = s1^s2 and exponent e1-e2+127 as a 10-bit signed value.
REQ-007 DIV SHALL perform exactly 26 radix-2 restoring iterations, one quotient bit per cycle.
REQ-008 After DIV, sticky SHALL be OR of the nonzero remainder.
REQ-009 ROUND SHALL:
- normalise so that quotient MSB=1 (decrementing the exponent when the first bit is 0);
- round to nearest, ties to even, using guard/round/sticky;
- propagate a mantissa carry into the exponent.
REQ-010 SHALL have a fixed latency: out_valid rises exactly 29 cycles after the accept edge for all operands, including special cases.
REQ-011 In DONE, y and out_valid SHALL hold stable until out_valid&&out_ready.
- On that cycle the FSM returns to IDLE, and out_valid=0 next cycle.
- No new accept occurs on the same cycle.
REQ-012 Special results SHALL override the arithmetic result:
- any NaN operand, 0/0 or inf/inf -> 32'h7fc00000;
- x/0 (x finite, nonzero) or inf/finite -> {sign,8'hff,23'b0};
- 0/x or finite/inf -> {sign,31'b0}.
REQ-013 An exponent >= 255 after rounding SHALL give {sign,8'hff,23'b0}.
REQ-014 Exponent underflow SHALL be handled per REQ-018/REQ-019.

Reset
REQ-015 On rst=1 at posedge, the FSM SHALL go to IDLE and in_ready=1, out_valid=0, y=32'h0, at any state, including mid-DIV.
REQ-016 Any in-flight operation SHALL be discarded silently on reset.

Configuration
REQ-017 Macro FDIV_SUBNORMAL_EN SHALL select subnormal handling.
REQ-018 With FDIV_SUBNORMAL_EN defined:
- subnormal inputs are normalised in PREP (leading-zero count, exponent adjusted);
- results below normal range are right-shifted into subnormal form, with shifted-out bits ORed into sticky, before rounding;
- latency is unchanged.
REQ-019 Without FDIV_SUBNORMAL_EN:
- subnormal inputs are treated as signed zero;
- results with biased exponent < 1 are flushed to {sign,31'b0}.

Structure
REQ-020 Package fpu_pkg SHALL hold:
- field widths (exponent 8, mantissa 23);
- BIAS=127;
- QNAN=32'h7fc00000;
- the FSM state enum type;
- the iteration count constant 26.
REQ-021 Leading-zero counting SHALL be a sub-module fdiv_lzc (24-bit input, 5-bit count), instantiated only under FDIV_SUBNORMAL_EN.
REQ-022 All state SHALL be in one always_ff; the datapath SHALL be iterative, using one 26-bit subtractor.

Verification
REQ-023 Bench SHALL cover:
- x1=32'h40c00000, x2=32'h40000000 -> y=32'h40400000 after exactly 29 cycles.
- x1=32'h3f800000, x2=32'h40400000 -> y=32'h3eaaaaab (rounding); and x1=32'hbf800000, x2=32'h00000000 -> y=32'hff800000.
- 0/0 -> 32'h7fc00000; x1=32'h7fc00001 (NaN) with any x2 -> 32'h7fc00000.
- x1=32'h00800000, x2=32'h40000000 -> 32'h00400000 with FDIV_SUBNORMAL_EN, 32'h00000000 without.
- out_ready held 0 for 10 cycles in DONE -> y/out_valid stable and in_ready=0. Then out_ready=1 -> in_ready=1 next cycle.
- rst pulsed at cycle 12 of DIV -> out_valid=0, in_ready=1 next cycle. A new 6.0/2.0 then yields 32'h40400000 after 29 cycles.
